// File: rtl/matrix_mac_sequencer.sv
// Purpose: sequences one dense-layer matrix-vector product (weight ROM x input RAM -> output RAM).
// Latency: start sampled in cycle 0, row r written in cycle (r+1)*(COLS+1), done in ROWS*(COLS+1)+1.
// Backpressure: none; memories must answer combinationally, start is ignored while busy, abort cancels.
module matrix_mac_sequencer #(
  parameter int ROWS      = 5,
  parameter int COLS      = 784,
  parameter int BASE_ADDR = 0,
  parameter int FRAC_BITS = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        relu_en,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [15:0] w_addr,
  input  logic [31:0] w_data,
  output logic [15:0] x_addr,
  input  logic [31:0] x_data,
  output logic        y_wr_en,
  output logic [15:0] y_addr,
  output logic [31:0] y_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [15:0] LAST_COL = 16'(COLS - 1);
  localparam logic [15:0] LAST_ROW = 16'(ROWS - 1);
  localparam logic [15:0] COLS16   = 16'(COLS);
  localparam logic [15:0] BASE16   = 16'(BASE_ADDR);

  localparam logic signed [63:0] SAT_HI = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] SAT_LO = 64'shFFFF_FFFF_8000_0000;

  logic [1:0]         state;
  logic [15:0]        row;
  logic [15:0]        col;
  logic [15:0]        row_base;
  logic               relu_q;
  logic signed [63:0] acc;
  logic [63:0]        prod;
  logic signed [63:0] shifted;
  logic [31:0]        result;

  // Low 64 bits of the product of the sign-extended operands equal the signed product.
  assign prod    = {{32{w_data[31]}}, w_data} * {{32{x_data[31]}}, x_data};
  assign shifted = acc >>> FRAC_BITS;

  // Scale, saturate to int32, then optional ReLU using the relu setting captured at start.
  always_comb begin
    result = shifted[31:0];
    if (shifted > SAT_HI) begin
      result = 32'h7FFF_FFFF;
    end else if (shifted < SAT_LO) begin
      result = 32'h8000_0000;
    end
    if (relu_q && result[31]) begin
      result = '0;
    end
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign y_wr_en = (state == S_WRITE);
  assign y_addr  = row;
  assign y_data  = y_wr_en ? result : '0;
  assign x_addr  = col;

  // Control FSM, counters, running row base and accumulator; abort outranks every transition.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      row      <= '0;
      col      <= '0;
      row_base <= '0;
      w_addr   <= '0;
      acc      <= '0;
      relu_q   <= 1'b0;
    end else if (abort && (state != S_IDLE)) begin
      state    <= S_IDLE;
      row      <= '0;
      col      <= '0;
      row_base <= '0;
      w_addr   <= '0;
      acc      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            row      <= '0;
            col      <= '0;
            acc      <= '0;
            relu_q   <= relu_en;
            row_base <= BASE16;
            w_addr   <= BASE16;
            state    <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + $signed(prod);
          if (col == LAST_COL) begin
            state <= S_WRITE;
          end else begin
            col    <= col + 16'd1;
            w_addr <= w_addr + 16'd1;
          end
        end
        S_WRITE: begin
          if (row == LAST_ROW) begin
            state <= S_DONE;
          end else begin
            row      <= row + 16'd1;
            col      <= '0;
            acc      <= '0;
            row_base <= row_base + COLS16;
            w_addr   <= row_base + COLS16;
            state    <= S_MAC;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Bench for matrix_mac_sequencer: three instances (2x3, 1x2 with FRAC_BITS=16 at base 100, 5x784).
// One instance runs at a time; its outputs are observed through a common selection mux.
// Expected results come from a plain-arithmetic dot-product model over the bench's memories.
module tb_matrix_mac_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, start, relu_en, abort;
  int   sel;
  int   ncmp = 0;
  int   nfail = 0;

  logic signed [31:0] mw [0:3919];
  logic signed [31:0] mx [0:783];

  logic        s_busy, s_done, s_wr, f_busy, f_done, f_wr, b_busy, b_done, b_wr;
  logic [15:0] s_wa, s_xa, s_ya, f_wa, f_xa, f_ya, b_wa, b_xa, b_ya;
  logic [31:0] s_wd, s_xd, s_yd, f_wd, f_xd, f_yd, b_wd, b_xd, b_yd;

  assign s_wd = (s_wa < 16'd6)   ? mw[s_wa] : '0;
  assign s_xd = (s_xa < 16'd3)   ? mx[s_xa] : '0;
  assign f_wd = (f_wa >= 16'd100 && f_wa < 16'd102) ? mw[f_wa - 16'd100] : '0;
  assign f_xd = (f_xa < 16'd2)   ? mx[f_xa] : '0;
  assign b_wd = (b_wa < 16'd3920) ? mw[b_wa] : '0;
  assign b_xd = (b_xa < 16'd784)  ? mx[b_xa] : '0;

  matrix_mac_sequencer #(.ROWS(2), .COLS(3), .BASE_ADDR(0), .FRAC_BITS(0)) u_small (
    .clk(clk), .resetn(resetn), .start(start && sel == 0), .relu_en(relu_en),
    .abort(abort && sel == 0), .busy(s_busy), .done(s_done), .w_addr(s_wa), .w_data(s_wd),
    .x_addr(s_xa), .x_data(s_xd), .y_wr_en(s_wr), .y_addr(s_ya), .y_data(s_yd));

  matrix_mac_sequencer #(.ROWS(1), .COLS(2), .BASE_ADDR(100), .FRAC_BITS(16)) u_frac (
    .clk(clk), .resetn(resetn), .start(start && sel == 1), .relu_en(relu_en),
    .abort(abort && sel == 1), .busy(f_busy), .done(f_done), .w_addr(f_wa), .w_data(f_wd),
    .x_addr(f_xa), .x_data(f_xd), .y_wr_en(f_wr), .y_addr(f_ya), .y_data(f_yd));

  matrix_mac_sequencer u_big (
    .clk(clk), .resetn(resetn), .start(start && sel == 2), .relu_en(relu_en),
    .abort(abort && sel == 2), .busy(b_busy), .done(b_done), .w_addr(b_wa), .w_data(b_wd),
    .x_addr(b_xa), .x_data(b_xd), .y_wr_en(b_wr), .y_addr(b_ya), .y_data(b_yd));

  logic        m_busy, m_done, m_wr;
  logic [15:0] m_wa, m_xa, m_ya;
  logic [31:0] m_yd;
  assign m_busy = (sel == 0) ? s_busy : (sel == 1) ? f_busy : b_busy;
  assign m_done = (sel == 0) ? s_done : (sel == 1) ? f_done : b_done;
  assign m_wr   = (sel == 0) ? s_wr   : (sel == 1) ? f_wr   : b_wr;
  assign m_wa   = (sel == 0) ? s_wa   : (sel == 1) ? f_wa   : b_wa;
  assign m_xa   = (sel == 0) ? s_xa   : (sel == 1) ? f_xa   : b_xa;
  assign m_ya   = (sel == 0) ? s_ya   : (sel == 1) ? f_ya   : b_ya;
  assign m_yd   = (sel == 0) ? s_yd   : (sel == 1) ? f_yd   : b_yd;

  // Dot product of weight row r with x, scaled, clamped to int32, optional ReLU.
  function automatic logic [31:0] model_y(input int r, input int cols, input int frac, input bit relu);
    longint acc;
    longint hi;
    longint lo;
    logic [31:0] y;
    hi  = 64'sd2147483647;
    lo  = -64'sd2147483648;
    acc = 0;
    for (int c = 0; c < cols; c++) acc += longint'(mw[r*cols + c]) * longint'(mx[c]);
    acc = acc >>> frac;
    if (acc > hi)      y = 32'h7FFF_FFFF;
    else if (acc < lo) y = 32'h8000_0000;
    else               y = acc[31:0];
    if (relu && y[31]) y = '0;
    return y;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full product on the selected instance; optional mid-run start pulse and relu toggle.
  task automatic run(input int rows, input int cols, input int base, input int frac,
                     input bit relu, input bit disturb);
    int lim, last_busy, pos, r, ndone, done_cyc, busy_bad, addr_bad;
    logic [31:0] wd[$];
    int          wc[$];
    logic [15:0] wa[$];
    lim = rows*(cols+1) + 6;
    last_busy = rows*(cols+1) + 1;
    ndone = 0; done_cyc = -1; busy_bad = 0; addr_bad = 0;
    @(negedge clk);
    start = 1'b1;
    relu_en = relu;
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      start   = disturb && (k == 3);
      relu_en = (disturb && k >= 2) ? ~relu : relu;
      if (m_busy !== (k <= last_busy)) busy_bad++;
      pos = (k - 1) % (cols + 1);
      r   = (k - 1) / (cols + 1);
      if (k < last_busy && pos < cols)
        if (m_wa !== 16'(base + r*cols + pos) || m_xa !== 16'(pos)) addr_bad++;
      if (m_wr) begin
        wd.push_back(m_yd);
        wc.push_back(k);
        wa.push_back(m_ya);
      end
      if (m_done) begin
        ndone++;
        done_cyc = k;
      end
    end
    start = 1'b0;
    relu_en = 1'b0;
    check("write_count", 64'(wd.size()), 64'(rows));
    for (int i = 0; i < wd.size() && i < rows; i++) begin
      check($sformatf("y_data[%0d]", i), {32'b0, wd[i]}, {32'b0, model_y(i, cols, frac, relu)});
      check($sformatf("y_cycle[%0d]", i), 64'(wc[i]), 64'((i + 1)*(cols + 1)));
      check($sformatf("y_addr[%0d]", i), {48'b0, wa[i]}, 64'(i));
    end
    check("done_cycle", 64'(done_cyc), 64'(last_busy));
    check("done_pulses", 64'(ndone), 64'd1);
    check("busy_profile_errs", 64'(busy_bad), 64'd0);
    check("addr_sweep_errs", 64'(addr_bad), 64'd0);
  endtask

  task automatic load_small(input int w0, w1, w2, w3, w4, w5, x0, x1, x2);
    mw[0] = w0; mw[1] = w1; mw[2] = w2; mw[3] = w3; mw[4] = w4; mw[5] = w5;
    mx[0] = x0; mx[1] = x1; mx[2] = x2;
  endtask

  initial begin
    int nwr, ndone, nwr_late;
    logic [31:0] first_y;
    resetn = 1'b0; start = 1'b0; relu_en = 1'b0; abort = 1'b0; sel = 0;
    for (int i = 0; i < 3920; i++) mw[i] = '0;
    for (int i = 0; i < 784; i++)  mx[i] = '0;

    // Reset state
    #1;
    check("rst_busy", 64'(m_busy), 64'd0);
    check("rst_done", 64'(m_done), 64'd0);
    check("rst_w_addr", 64'(m_wa), 64'd0);
    check("rst_x_addr", 64'(m_xa), 64'd0);
    check("rst_y_wr_en", 64'(m_wr), 64'd0);
    check("rst_y_addr", 64'(m_ya), 64'd0);
    check("rst_y_data", 64'(m_yd), 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Basic 2x3 product: y = {6, 15}
    load_small(1, 2, 3, 4, 5, 6, 1, 1, 1);
    run(2, 3, 0, 0, 1'b0, 1'b0);

    // Negative results with and without ReLU
    load_small(-1, -2, -3, 1, 1, 1, 1, 1, 1);
    run(2, 3, 0, 0, 1'b1, 1'b0);
    run(2, 3, 0, 0, 1'b0, 1'b0);
    check("explicit_neg6", {32'b0, model_y(0, 3, 0, 1'b0)}, 64'hFFFF_FFFA);

    // Saturation both ways: row 0 saturates high, row 1 low
    load_small(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, -32'sh7FFF_FFFF, -32'sh7FFF_FFFF, 0,
               32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
    run(2, 3, 0, 0, 1'b0, 1'b0);

    // Control: start re-pulsed and relu toggled mid-run must not matter
    load_small(-1, -2, -3, 1, 1, 1, 1, 1, 1);
    run(2, 3, 0, 0, 1'b0, 1'b1);

    // Abort in cycle 5 (first row-1 MAC cycle)
    load_small(1, 2, 3, 4, 5, 6, 1, 1, 1);
    nwr = 0; ndone = 0; first_y = '0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (k == 5);
      if (k == 6) check("abort_busy_c6", 64'(m_busy), 64'd0);
      if (m_wr) begin
        nwr++;
        first_y = m_yd;
      end
      if (m_done) ndone++;
    end
    abort = 1'b0;
    check("abort_writes", 64'(nwr), 64'd1);
    check("abort_y0", {32'b0, first_y}, 64'd6);
    check("abort_no_done", 64'(ndone), 64'd0);
    run(2, 3, 0, 0, 1'b0, 1'b0);

    // Asynchronous reset during row-1 MAC
    nwr = 0; nwr_late = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 6) begin
        resetn = 1'b0;
        #1;
        check("arst_busy", 64'(m_busy), 64'd0);
        check("arst_w_addr", 64'(m_wa), 64'd0);
        check("arst_x_addr", 64'(m_xa), 64'd0);
        check("arst_y_wr_en", 64'(m_wr), 64'd0);
        check("arst_y_data", 64'(m_yd), 64'd0);
        check("arst_done", 64'(m_done), 64'd0);
      end
      if (k == 9) resetn = 1'b1;
      if (m_wr) begin
        nwr++;
        if (k >= 6) nwr_late++;
      end
    end
    check("arst_total_writes", 64'(nwr), 64'd1);
    check("arst_late_writes", 64'(nwr_late), 64'd0);
    run(2, 3, 0, 0, 1'b1, 1'b0);

    // Random 2x3 products, alternating full-range and small operands
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 6; i++)
        mw[i] = (it % 2 == 0) ? $urandom() : $signed($urandom_range(200)) - 100;
      for (int i = 0; i < 3; i++)
        mx[i] = (it % 2 == 0) ? $urandom() : $signed($urandom_range(200)) - 100;
      run(2, 3, 0, 0, 1'($urandom_range(1)), 1'b0);
    end

    // Fractional scaling on the 1x2 instance at base address 100
    sel = 1;
    mw[0] = 32'h0001_0000; mw[1] = 0; mx[0] = 32'h0003_0000; mx[1] = 0;
    run(1, 2, 100, 16, 1'b0, 1'b0);
    check("explicit_frac", {32'b0, model_y(0, 2, 16, 1'b0)}, 64'h0003_0000);
    for (int it = 0; it < 4; it++) begin
      mw[0] = $urandom(); mw[1] = $urandom(); mx[0] = $urandom(); mx[1] = $urandom();
      run(1, 2, 100, 16, 1'($urandom_range(1)), 1'b0);
    end

    // Default geometry 5x784 with random weights and inputs
    sel = 2;
    for (int i = 0; i < 3920; i++) mw[i] = $signed($urandom_range(4095)) - 2048;
    for (int i = 0; i < 784; i++)  mx[i] = $signed($urandom_range(2047)) - 1024;
    run(5, 784, 0, 0, 1'b0, 1'b0);
    run(5, 784, 0, 0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
